// File: rtl/lcd_out_ctrl_if.sv
// Pixel-in / LCD-out bundle for lcd_out_ctrl; the slave side is the controller.
// Carries the scaler pixel stream, the LCD panel bus and the FIFO status taps.
interface lcd_out_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 4
);
    logic [DATA_WIDTH-1:0] dIn;
    logic                  dInEn;
    logic                  VS;
    logic [DATA_WIDTH-1:0] lcdData;
    logic                  lcdDe;
    logic                  lcdHsyn;
    logic                  lcdVsyn;
    logic [FIFO_AW:0]      fifoCnt;
    logic                  ovf;
    logic                  udf;

    modport master (
        output dIn, dInEn, VS,
        input  lcdData, lcdDe, lcdHsyn, lcdVsyn, fifoCnt, ovf, udf
    );

    modport slave (
        input  dIn, dInEn, VS,
        output lcdData, lcdDe, lcdHsyn, lcdVsyn, fifoCnt, ovf, udf
    );
endinterface

// File: rtl/lcd_out_ctrl.sv
// LCD timing generator fed by a small pixel FIFO; outputs are 1 clock behind the h/v counters.
// No backpressure: pixels arriving at a full FIFO are dropped (ovf), and reads from an empty FIFO emit 0 (udf).
module lcd_out_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int PRIME_LVL  = 8,
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 2,
    parameter int H_SYNC     = 41,
    parameter int H_BP       = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BP       = 2,
    parameter int CNT_W      = 11
) (
    input  logic          clk,
    input  logic          rst,
    lcd_out_ctrl_if.slave io
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYN_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYN_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] PRIME_C   = (FIFO_AW+1)'(PRIME_LVL);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  vs_q, vs_d;
    logic [CNT_W-1:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  de_q, de_d, hsyn_q, hsyn_d, vsyn_q, vsyn_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic running, h_act, h_syn, v_act, v_syn, frame_start;
    logic rd_req, rd_ok, wr_req, wr_ok;

    always_comb begin
        running     = (state_q == RUN);
        h_act       = (h_cnt_q < H_ACT_END);
        h_syn       = (h_cnt_q >= H_SYN_BEG) && (h_cnt_q < H_SYN_END);
        v_act       = (v_cnt_q < V_ACT_END);
        v_syn       = (v_cnt_q >= V_SYN_BEG) && (v_cnt_q < V_SYN_END);
        frame_start = running && (h_cnt_q == '0) && (v_cnt_q == '0);

        // No bypass: an empty FIFO fails the read even if a write lands this cycle.
        rd_req = running && h_act && v_act;
        rd_ok  = rd_req && (cnt_q != '0);
        wr_req = io.dInEn && (state_q != IDLE);
        wr_ok  = wr_req && ((cnt_q != FULL_LVL) || rd_ok);

        state_d  = state_q;
        vs_d     = io.VS;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (wr_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (io.VS && !vs_q) begin
                    state_d  = PRIME;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end
            end
            PRIME: begin
                if (cnt_q >= PRIME_C) begin
                    state_d = RUN;
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                end
            end
            RUN: begin
                // Free-running raster: never stalls on underflow.
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        de_d   = rd_req;
        hsyn_d = !(running && h_syn);
        vsyn_d = !(running && v_syn);
        data_d = rd_ok ? mem_q[rd_ptr_q] : '0;

        // A set in the frame-start cycle outranks the clear.
        ovf_d = (wr_req && !wr_ok) || (ovf_q && !frame_start);
        udf_d = (rd_req && !rd_ok) || (udf_q && !frame_start);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= io.dIn;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            de_q     <= 1'b0;
            hsyn_q   <= 1'b1;
            vsyn_q   <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            de_q     <= de_d;
            hsyn_q   <= hsyn_d;
            vsyn_q   <= vsyn_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign io.lcdData = data_q;
    assign io.lcdDe   = de_q;
    assign io.lcdHsyn = hsyn_q;
    assign io.lcdVsyn = vsyn_q;
    assign io.fifoCnt = cnt_q;
    assign io.ovf     = ovf_q;
    assign io.udf     = udf_q;
endmodule

// File: doc/lcd_out_ctrl.md
LCD_OUT_CTRL -- requirements
Module: lcd_out_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_WIDTH, 16, pixel width
- FIFO_AW, 4, FIFO address width (depth 2^FIFO_AW)
- PRIME_LVL, 8, FIFO fill level that starts timing
- H_ACTIVE/H_FP/H_SYNC/H_BP, 480/2/41/2, horizontal region lengths in clocks
- V_ACTIVE/V_FP/V_SYNC/V_BP, 272/2/10/2, vertical region lengths in lines
- CNT_W, 11, width of hCnt and vCnt

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock (pixel clock, same domain as the scaler output clock clkb)
- rst, in, 1, reset; synchronous, active-low
- dIn, in, DATA_WIDTH, pixel from scaler dOut
- dInEn, in, 1, pixel valid, from scaler dOutEn
- VS, in, 1, scaler frame sync; rising edge marks a new frame
- lcdData, out, DATA_WIDTH, LCD pixel bus
- lcdDe, out, 1, LCD data enable
- lcdHsyn, out, 1, LCD hsync, active-low
- lcdVsyn, out, 1, LCD vsync, active-low
- fifoCnt, out, FIFO_AW+1, current FIFO occupancy
- ovf, out, 1, sticky overflow flag
- udf, out, 1, sticky underflow flag

Function
REQ-003 The internal FIFO SHALL be synchronous and single-clock, with 2^FIFO_AW entries, wrap-around pointers, and fifoCnt ranging 0..2^FIFO_AW.
REQ-004 A write SHALL occur when dInEn=1 and the FIFO is not full; when dInEn=1 and the FIFO is full, the pixel SHALL be dropped and ovf SHALL be set.
REQ-005 A simultaneous read and write on a full FIFO SHALL both succeed, leaving fifoCnt unchanged.
REQ-006 A read on an empty FIFO SHALL fail and set udf, even with a same-cycle write (no bypass); that write SHALL still be stored.
REQ-007 The FSM SHALL have three states, IDLE, PRIME and RUN, and SHALL enter IDLE on reset.
REQ-008 IDLE: the FIFO SHALL ignore writes; on a VS rising edge (VS=1, previous VS=0) the block SHALL flush the FIFO (fifoCnt to 0) and go to PRIME.
REQ-009 PRIME: the FIFO SHALL accept writes; in the cycle after fifoCnt>=PRIME_LVL the FSM SHALL go to RUN with hCnt=0 and vCnt=0.
REQ-010 RUN: hCnt SHALL count 0..H_TOT-1, where H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0 and increment vCnt; vCnt SHALL wrap at V_TOT, defined the same way.
REQ-011 Region order within each count SHALL be active, front porch, sync, back porch:
- hAct = hCnt<H_ACTIVE
- hSyn = H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC
- vAct and vSyn are defined identically on vCnt.
REQ-012 In RUN, a FIFO read SHALL be requested in every cycle with hAct and vAct.
REQ-013 Outputs SHALL be registered with 1-clock latency from the counters:
- lcdDe <= hAct&vAct
- lcdHsyn <= ~hSyn
- lcdVsyn <= ~vSyn
- lcdData <= FIFO head on a successful read; 0 on underflow or when not active
REQ-014 RUN SHALL stay in RUN after an underflow; the timing SHALL never stall.
REQ-015 ovf and udf SHALL clear at the frame start (hCnt=0, vCnt=0 in RUN); a same-cycle set SHALL win over the clear.
REQ-016 In IDLE and PRIME: lcdDe=0, lcdHsyn=1, lcdVsyn=1, lcdData=0.
REQ-017 A VS rising edge in PRIME or RUN SHALL be ignored; resynchronisation requires reset.

Reset
REQ-018 When rst=0 at a clk edge, the following SHALL hold from the next cycle:
- state=IDLE, hCnt=0, vCnt=0
- FIFO pointers 0, fifoCnt=0
- lcdData=0, lcdDe=0, lcdHsyn=1, lcdVsyn=1
- ovf=0, udf=0
REQ-019 Reset asserted mid-frame SHALL abort immediately, with no completion of the current line; all buffered pixels SHALL be discarded.

Verification
Bench parameters: H 4/1/2/1 (H_TOT=8), V 2/1/1/1 (V_TOT=5), FIFO_AW=3, PRIME_LVL=4.
REQ-020 Prime: VS rise, then 4 pixels 0x0001..0x0004 on consecutive cycles -> RUN one cycle after fifoCnt=4; first lcdDe=1 one cycle after RUN entry, with lcdData=0x0001.
REQ-021 Timing: continuous supply of pixels in RUN -> lcdDe high 4 of every 8 clocks on lines 0-1 only; lcdHsyn low for 2 clocks starting 5 clocks after each lcdDe rise; lcdVsyn low for the whole of line 3.
REQ-022 Overflow: in PRIME, hold the timing off by writing 9 pixels back-to-back -> the first 8 are stored and the 9th sets ovf=1; ovf clears at the next frame start.
REQ-023 Underflow: in RUN, stop dInEn -> after the FIFO drains, lcdData=0 with lcdDe=1, udf=1, and hCnt continues uninterrupted.
REQ-024 Reset: pull rst low mid-active-line -> next cycle all outputs are at reset values; a VS rising edge is then required before any lcdDe=1.
REQ-025 Edge cases: a full FIFO with read and write in the same cycle -> fifoCnt stays 8 with no ovf; an empty FIFO with read and write in the same cycle -> udf=1 and fifoCnt becomes 1.
